// File: rtl/wb_master_bridge.sv
// wb_master_bridge: single-outstanding WISHBONE master.
// A client posts one read/write command at a time. The bridge runs the
// bus cycle, applies an ack timeout and returns a one-cycle response
// strobe carrying read data or a timeout error.
// Optional feature: define WB_MASTER_RETRY_EN to retry a command once
// after its first timeout, with a one-cycle bus release (BACKOFF) in between.
module wb_master_bridge #(
  parameter int ADR_W          = 26,
  parameter int DAT_W          = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SSP_BIT        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  output logic             rsp_valid_o,
  output logic [DAT_W-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  output logic             we_o,
  output logic             stb_o,
  output logic             cyc_o,
  output logic             taga_o,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             ack_i,
  input  logic             tagd_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
`ifdef WB_MASTER_RETRY_EN
    , S_BACKOFF
`endif
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic             retried_q, retried_d;

  // tagd_i marks SSP reads on the slave side; control never depends on it
  logic unused_tagd;
  assign unused_tagd = tagd_i;

  // Next-state and next-output logic for the bus-cycle FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    retried_d   = retried_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          adr_d     = cmd_adr_i;
          dat_d     = cmd_dat_i;
          we_d      = cmd_we_i;
          cyc_d     = 1'b1;
          ready_d   = 1'b0;
          retried_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ack_i) begin
          // SSP region only drives byte 0 of read data
          if (!we_q)
            rsp_dat_d = adr_q[SSP_BIT] ? {{(DAT_W-8){1'b0}}, dat_i[7:0]} : dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          state_d     = S_DONE;
        end else if (cnt_q == TO_LAST) begin
`ifdef WB_MASTER_RETRY_EN
          if (!retried_q) begin
            retried_d = 1'b1;
            cyc_d     = 1'b0;
            state_d   = S_BACKOFF;
          end else
`endif
          begin
            rsp_dat_d   = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            cyc_d       = 1'b0;
            we_d        = 1'b0;
            state_d     = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef WB_MASTER_RETRY_EN
      S_BACKOFF: begin
        // bus released for one cycle; adr/dat/we kept for the retry
        cyc_d   = 1'b1;
        state_d = S_REQ;
      end
`endif
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      retried_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      retried_q   <= retried_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign taga_o      = ~cyc_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;

endmodule
